// File: rtl/axi_mem_resp_pkg.sv
// axi_mem_resp_pkg
//   Shared types and constants for the AXI memory responder.
//   state_e  : responder FSM states
//   BEAT_W   : beat width in bits for the default DQ width
//   STRB_W   : byte strobes per beat for the default DQ width
//   ADDR_LSB : address bits below one beat (8 DQ-word units per beat)
package axi_mem_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_DATA  = 3'd1,
    ST_WR_RESP  = 3'd2,
    ST_RD_FETCH = 3'd3,
    ST_RD_DATA  = 3'd4
  } state_e;

  localparam int DQ_WIDTH_DEF = 32;
  localparam int BEAT_W       = DQ_WIDTH_DEF * 8;
  localparam int STRB_W       = DQ_WIDTH_DEF;
  localparam int ADDR_LSB     = 3;

endpackage

// File: rtl/axi_mem_resp_bram.sv
// resp_bram
//   Single-port beat-wide RAM with byte enables and a one-cycle registered
//   read. Contents and read register are not reset.
//   i_clk   : clock
//   i_en    : port enable (read when i_we low, write when i_we high)
//   i_we    : write enable
//   i_addr  : word index
//   i_wdata : write data, i_strb : per-byte write enables
//   o_rdata : read data, valid the cycle after an enabled read
module resp_bram
  import axi_mem_resp_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = BEAT_W,
  parameter int NB     = STRB_W
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [NB-1:0]     i_strb,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < NB; b++) begin
          if (i_strb[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end else begin
        o_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/axi_mem_resp.sv
// axi_mem_resp
//   AXI slave that replaces the DDR controller plus memory behind the frame
//   buffer. One burst at a time; the slave drives axi_wlast. Bursts are INCR
//   of full beats, index = addr[MEM_DEPTH_LOG2+2:3], wrapping in the RAM.
//   ddr_clk / ddr_rst        : clock, synchronous active-high reset
//   axi_aw* / axi_awready    : write address channel
//   axi_w*  / axi_wready/wlast: write data channel (wlast generated here)
//   axi_b*                   : write response, bresp always OKAY
//   axi_ar* / axi_arready    : read address channel
//   axi_r*                   : read data channel, rresp always OKAY
//
// state       | meaning
// ST_IDLE     | arbitrate AW/AR, capture burst on handshake
// ST_WR_DATA  | accept one W beat per cycle into the RAM
// ST_WR_RESP  | present bvalid until bready
// ST_RD_FETCH | RAM read of the current index in flight
// ST_RD_DATA  | present read beat, hold until rready
module axi_mem_resp
  import axi_mem_resp_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = DQ_WIDTH_DEF,
  parameter int MEM_DEPTH_LOG2  = 10
) (
  input  logic                       ddr_clk,
  input  logic                       ddr_rst,
  input  logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [3:0]                 axi_awid,
  input  logic [3:0]                 axi_awlen,
  input  logic [2:0]                 axi_awsize,
  input  logic [1:0]                 axi_awburst,
  input  logic                       axi_awvalid,
  output logic                       axi_awready,
  input  logic [MEM_DQ_WIDTH*8-1:0]  axi_wdata,
  input  logic [MEM_DQ_WIDTH-1:0]    axi_wstrb,
  input  logic                       axi_wvalid,
  output logic                       axi_wready,
  output logic                       axi_wlast,
  output logic [3:0]                 axi_bid,
  output logic [1:0]                 axi_bresp,
  output logic                       axi_bvalid,
  input  logic                       axi_bready,
  input  logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
  input  logic [3:0]                 axi_arid,
  input  logic [3:0]                 axi_arlen,
  input  logic [2:0]                 axi_arsize,
  input  logic [1:0]                 axi_arburst,
  input  logic                       axi_arvalid,
  output logic                       axi_arready,
  output logic [MEM_DQ_WIDTH*8-1:0]  axi_rdata,
  output logic [3:0]                 axi_rid,
  output logic [1:0]                 axi_rresp,
  output logic                       axi_rvalid,
  output logic                       axi_rlast,
  input  logic                       axi_rready
);

  localparam int IDX_W = MEM_DEPTH_LOG2;

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_prio_rd;   // tie goes to read when set
  logic [IDX_W-1:0]     r_idx;
  logic [3:0]           r_id;
  logic [3:0]           r_len;
  logic [3:0]           r_beat_cnt;

  logic                 w_last;
  logic                 w_grant_wr;
  logic                 w_aw_hs;
  logic                 w_ar_hs;
  logic                 w_w_beat;
  logic                 w_r_hs;
  logic                 w_ram_en;
  logic [MEM_DQ_WIDTH*8-1:0] w_ram_rdata;

  // Size/burst are implied (INCR, full beat); address bits outside the
  // index are don't-care.
  logic w_unused;
  assign w_unused = ^{axi_awsize, axi_awburst, axi_arsize, axi_arburst,
                      axi_awaddr, axi_araddr};

  always_comb begin
    w_state_nxt = r_state;
    axi_awready = 1'b0;
    axi_arready = 1'b0;
    axi_wready  = 1'b0;
    axi_wlast   = 1'b0;
    axi_bvalid  = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rlast   = 1'b0;
    w_last      = (r_beat_cnt == r_len);
    w_grant_wr  = axi_awvalid & (~axi_arvalid | ~r_prio_rd);

    unique case (r_state)
      ST_IDLE: begin
        axi_awready = w_grant_wr;
        axi_arready = axi_arvalid & ~w_grant_wr;
        if (w_grant_wr)       w_state_nxt = ST_WR_DATA;
        else if (axi_arvalid) w_state_nxt = ST_RD_FETCH;
      end
      ST_WR_DATA: begin
        axi_wready = 1'b1;
        axi_wlast  = w_last;
        if (axi_wvalid && w_last) w_state_nxt = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        axi_bvalid = 1'b1;
        if (axi_bready) w_state_nxt = ST_IDLE;
      end
      ST_RD_FETCH: begin
        w_state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        axi_rvalid = 1'b1;
        axi_rlast  = w_last;
        if (axi_rready) w_state_nxt = w_last ? ST_IDLE : ST_RD_FETCH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Handshake-side outputs must be silent while reset is held so nothing
    // is accepted on the reset edge.
    if (ddr_rst) begin
      axi_awready = 1'b0;
      axi_arready = 1'b0;
      axi_wready  = 1'b0;
      axi_wlast   = 1'b0;
    end
  end

  assign w_aw_hs  = axi_awvalid & axi_awready;
  assign w_ar_hs  = axi_arvalid & axi_arready;
  assign w_w_beat = axi_wvalid & axi_wready;
  assign w_r_hs   = axi_rvalid & axi_rready;

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      r_prio_rd  <= 1'b0;
      r_idx      <= '0;
      r_id       <= 4'd0;
      r_len      <= 4'd0;
      r_beat_cnt <= 4'd0;
    end else if (w_aw_hs) begin
      r_idx      <= axi_awaddr[ADDR_LSB +: IDX_W];
      r_id       <= axi_awid;
      r_len      <= axi_awlen;
      r_beat_cnt <= 4'd0;
      r_prio_rd  <= 1'b1;
    end else if (w_ar_hs) begin
      r_idx      <= axi_araddr[ADDR_LSB +: IDX_W];
      r_id       <= axi_arid;
      r_len      <= axi_arlen;
      r_beat_cnt <= 4'd0;
      r_prio_rd  <= 1'b0;
    end else if (w_w_beat || (w_r_hs && !w_last)) begin
      r_idx      <= r_idx + IDX_W'(1);
      r_beat_cnt <= r_beat_cnt + 4'd1;
    end
  end

  // Read port is only enabled in RD_FETCH, so the RAM output register holds
  // the beat steady for as long as rready stalls RD_DATA.
  assign w_ram_en = w_w_beat | (r_state == ST_RD_FETCH);

  resp_bram #(
    .ADDR_W (IDX_W),
    .DATA_W (MEM_DQ_WIDTH*8),
    .NB     (MEM_DQ_WIDTH)
  ) u_bram (
    .i_clk   (ddr_clk),
    .i_en    (w_ram_en),
    .i_we    (w_w_beat),
    .i_addr  (r_idx),
    .i_wdata (axi_wdata),
    .i_strb  (axi_wstrb),
    .o_rdata (w_ram_rdata)
  );

  // The RAM read register has no reset; mask it so rdata is zero outside
  // RD_DATA, including straight after reset.
  assign axi_rdata = axi_rvalid ? w_ram_rdata : '0;
  assign axi_rid   = r_id;
  assign axi_bid   = r_id;
  assign axi_bresp = 2'b00;
  assign axi_rresp = 2'b00;

endmodule

// File: tb/tb_axi_mem_resp.sv
module tb_axi_mem_resp;

  localparam int AW = 28;
  localparam int BW = 256;
  localparam int SW = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] awaddr = '0;
  logic [3:0]    awid = '0, awlen = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [BW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready, wlast;
  logic [3:0]    bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b1;
  logic [AW-1:0] araddr = '0;
  logic [3:0]    arid = '0, arlen = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [BW-1:0] rdata;
  logic [3:0]    rid;
  logic [1:0]    rresp;
  logic          rvalid, rlast;
  logic          rready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [BW-1:0] mem_m [DEPTH];
  logic [BW-1:0] wd [16];
  logic [SW-1:0] ws [16];

  always #5 clk = ~clk;

  axi_mem_resp #(
    .CTRL_ADDR_WIDTH (AW),
    .MEM_DQ_WIDTH    (32),
    .MEM_DEPTH_LOG2  (4)
  ) dut (
    .ddr_clk     (clk),
    .ddr_rst     (rst),
    .axi_awaddr  (awaddr),
    .axi_awid    (awid),
    .axi_awlen   (awlen),
    .axi_awsize  (3'd5),
    .axi_awburst (2'd1),
    .axi_awvalid (awvalid),
    .axi_awready (awready),
    .axi_wdata   (wdata),
    .axi_wstrb   (wstrb),
    .axi_wvalid  (wvalid),
    .axi_wready  (wready),
    .axi_wlast   (wlast),
    .axi_bid     (bid),
    .axi_bresp   (bresp),
    .axi_bvalid  (bvalid),
    .axi_bready  (bready),
    .axi_araddr  (araddr),
    .axi_arid    (arid),
    .axi_arlen   (arlen),
    .axi_arsize  (3'd5),
    .axi_arburst (2'd1),
    .axi_arvalid (arvalid),
    .axi_arready (arready),
    .axi_rdata   (rdata),
    .axi_rid     (rid),
    .axi_rresp   (rresp),
    .axi_rvalid  (rvalid),
    .axi_rlast   (rlast),
    .axi_rready  (rready)
  );

  function automatic logic [BW-1:0] rnd256();
    logic [BW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int beat_index(input logic [AW-1:0] addr, input int k);
    return (int'(addr / 28'd8) + k) % DEPTH;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [3:0] id,
                           input logic [3:0] len, input int stall_beat,
                           input int stall_cyc, input bit both, input string tag);
    int guard;
    int idx;
    logic exp_last;
    @(negedge clk);
    awaddr = addr; awid = id; awlen = len; awvalid = 1'b1;
    if (both) begin
      araddr = AW'($urandom); arid = ~id; arlen = 4'd0; arvalid = 1'b1;
    end
    #1;
    guard = 0;
    while (awready !== 1'b1 && guard < 8) begin
      @(negedge clk); #1; guard++;
    end
    n_vec++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      n_err++;
      $display("FAIL %s aw_grant: awready=%b arready=%b, required 1/0", tag, awready, arready);
      awvalid = 1'b0; arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 0; k <= int'(len); k++) begin
      @(negedge clk);
      awvalid = 1'b0; arvalid = 1'b0;
      exp_last = (k == int'(len));
      if (k == stall_beat) begin
        for (int s = 0; s < stall_cyc; s++) begin
          wvalid = 1'b0; wdata = rnd256(); wstrb = '1; #1;
          n_vec++;
          if (wready !== 1'b1 || wlast !== exp_last) begin
            n_err++;
            $display("FAIL %s w_stall beat %0d: wready=%b wlast=%b, required 1/%b", tag, k, wready, wlast, exp_last);
          end
          @(negedge clk);
        end
      end
      wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k]; #1;
      n_vec++;
      if (wready !== 1'b1 || wlast !== exp_last) begin
        n_err++;
        $display("FAIL %s w_beat %0d: wready=%b wlast=%b, required 1/%b", tag, k, wready, wlast, exp_last);
      end
      idx = beat_index(addr, k);
      for (int b = 0; b < SW; b++)
        if (ws[k][b]) mem_m[idx][b*8 +: 8] = wd[k][b*8 +: 8];
      @(posedge clk);
    end
    @(negedge clk);
    wvalid = 1'b0; #1;
    n_vec++;
    if (bvalid !== 1'b1 || bid !== id || bresp !== 2'b00) begin
      n_err++;
      $display("FAIL %s b_resp: bvalid=%b bid=%h bresp=%b, required 1/%h/00", tag, bvalid, bid, id, bresp);
    end
    @(posedge clk);
    @(negedge clk); #1;
    n_vec++;
    if (bvalid !== 1'b0) begin
      n_err++;
      $display("FAIL %s b_done: bvalid=%b, required 0", tag, bvalid);
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [3:0] id,
                          input logic [3:0] len, input int stall_beat,
                          input int stall_cyc, input bit both, input string tag,
                          output logic [BW-1:0] first);
    int guard;
    logic exp_last;
    logic [BW-1:0] exp;
    first = 'x;
    @(negedge clk);
    araddr = addr; arid = id; arlen = len; arvalid = 1'b1;
    if (both) begin
      awaddr = AW'($urandom); awid = ~id; awlen = 4'd0; awvalid = 1'b1;
    end
    #1;
    guard = 0;
    while (arready !== 1'b1 && guard < 8) begin
      @(negedge clk); #1; guard++;
    end
    n_vec++;
    if (arready !== 1'b1 || awready !== 1'b0) begin
      n_err++;
      $display("FAIL %s ar_grant: arready=%b awready=%b, required 1/0", tag, arready, awready);
      arvalid = 1'b0; awvalid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 0; k <= int'(len); k++) begin
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0; rready = 1'b0; #1;
      n_vec++;
      if (rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL %s r_fetch_gap beat %0d: rvalid=%b, required 0", tag, k, rvalid);
      end
      @(negedge clk); #1;
      exp = mem_m[beat_index(addr, k)];
      exp_last = (k == int'(len));
      n_vec++;
      if (rvalid !== 1'b1 || rdata !== exp || rlast !== exp_last || rid !== id || rresp !== 2'b00) begin
        n_err++;
        $display("FAIL %s r_beat %0d: rvalid=%b rlast=%b rid=%h rdata=%h, required 1/%b/%h/%h",
                 tag, k, rvalid, rlast, rid, rdata, exp_last, id, exp);
      end
      if (k == 0) first = rdata;
      if (k == stall_beat) begin
        for (int s = 0; s < stall_cyc; s++) begin
          @(negedge clk); #1;
          n_vec++;
          if (rvalid !== 1'b1 || rdata !== exp || rlast !== exp_last) begin
            n_err++;
            $display("FAIL %s r_stall beat %0d: rvalid=%b rlast=%b rdata=%h, required 1/%b/%h",
                     tag, k, rvalid, rlast, rdata, exp_last, exp);
          end
        end
      end
      rready = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    rready = 1'b0; #1;
    n_vec++;
    if (rvalid !== 1'b0 || rlast !== 1'b0) begin
      n_err++;
      $display("FAIL %s r_done: rvalid=%b rlast=%b, required 0/0", tag, rvalid, rlast);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (awready !== 1'b0 || arready !== 1'b0 || wready !== 1'b0 || wlast !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: awready=%b arready=%b wready=%b wlast=%b, required 0000",
               awready, arready, wready, wlast);
    end
    n_vec++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== '0 || rid !== 4'd0 || bid !== 4'd0) begin
      n_err++;
      $display("FAIL reset_outputs: bvalid=%b rvalid=%b rlast=%b rid=%h bid=%h rdata=%h, required all 0",
               bvalid, rvalid, rlast, rid, bid, rdata);
    end
    awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [BW-1:0] d;
    for (int k = 0; k < 16; k++) begin wd[k] = rnd256(); ws[k] = '1; end
    axi_write(28'h0, 4'h1, 4'd15, -1, 0, 1'b0, "fill");
    axi_read(28'h0, 4'h2, 4'd15, -1, 0, 1'b0, "fill_rd", d);
  endtask

  task automatic test_arbitration();
    logic [BW-1:0] d;
    do_reset();
    wd[0] = rnd256(); ws[0] = '1;
    axi_write(28'h08, 4'h4, 4'd0, -1, 0, 1'b1, "arb_w1");
    axi_read(28'h08, 4'h5, 4'd0, -1, 0, 1'b1, "arb_r2", d);
    wd[0] = rnd256(); ws[0] = '1;
    axi_write(28'h10, 4'h6, 4'd0, -1, 0, 1'b1, "arb_w3");
  endtask

  task automatic test_write_read();
    logic [BW-1:0] d;
    for (int k = 0; k < 8; k++) begin wd[k] = BW'(k); ws[k] = '1; end
    axi_write(28'h40, 4'h3, 4'd7, -1, 0, 1'b0, "wr_rd_w");
    axi_read(28'h40, 4'h9, 4'd7, -1, 0, 1'b0, "wr_rd_r", d);
    n_vec++;
    if (d !== BW'(0)) begin
      n_err++;
      $display("FAIL wr_rd_first: rdata=%h, required 0", d);
    end
  endtask

  task automatic test_strobes();
    logic [BW-1:0] d;
    logic [BW-1:0] exp;
    exp = '1;
    exp[7:0] = 8'h00;
    wd[0] = '1; ws[0] = '1;
    axi_write(28'h0, 4'hA, 4'd0, -1, 0, 1'b0, "strb_ones");
    wd[0] = '0; ws[0] = 32'h0000_0001;
    axi_write(28'h0, 4'hB, 4'd0, -1, 0, 1'b0, "strb_byte0");
    axi_read(28'h0, 4'hC, 4'd0, -1, 0, 1'b0, "strb_rd", d);
    n_vec++;
    if (d !== exp) begin
      n_err++;
      $display("FAIL strobe_bytes: rdata=%h, required %h", d, exp);
    end
  endtask

  task automatic test_wrap();
    logic [BW-1:0] d;
    wd[0] = rnd256(); wd[1] = rnd256(); ws[0] = '1; ws[1] = '1;
    axi_write(28'h78, 4'h7, 4'd1, -1, 0, 1'b0, "wrap_w");
    axi_read(28'h0, 4'h8, 4'd0, -1, 0, 1'b0, "wrap_r0", d);
    n_vec++;
    if (d !== wd[1]) begin
      n_err++;
      $display("FAIL wrap_index0: rdata=%h, required %h", d, wd[1]);
    end
    axi_read(28'h78, 4'h8, 4'd1, -1, 0, 1'b0, "wrap_r15", d);
  endtask

  task automatic test_stalls();
    logic [BW-1:0] d;
    for (int k = 0; k < 8; k++) begin wd[k] = rnd256(); ws[k] = '1; end
    axi_write(28'h18, 4'hD, 4'd7, 3, 3, 1'b0, "stall_w");
    axi_read(28'h18, 4'hE, 4'd7, 2, 5, 1'b0, "stall_r", d);
  endtask

  task automatic test_random();
    logic [BW-1:0] d;
    logic [3:0] len;
    for (int t = 0; t < 8; t++) begin
      len = 4'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) begin
        wd[k] = rnd256();
        ws[k] = ($urandom_range(0, 3) == 0) ? '1 : SW'($urandom);
      end
      axi_write(AW'($urandom), 4'($urandom), len, int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), 1'b0, "rand_w");
      axi_read(AW'($urandom), 4'($urandom), 4'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 1'b0, "rand_r", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] d;
    int guard;
    for (int k = 0; k < 16; k++) begin wd[k] = rnd256(); ws[k] = '1; end
    @(negedge clk);
    awaddr = 28'h20; awid = 4'h5; awlen = 4'd15; awvalid = 1'b1; #1;
    guard = 0;
    while (awready !== 1'b1 && guard < 8) begin
      @(negedge clk); #1; guard++;
    end
    n_vec++;
    if (awready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid aw_grant: awready=%b, required 1", awready);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b1; wdata = wd[k]; wstrb = '1;
      mem_m[beat_index(28'h20, k)] = wd[k];
      @(posedge clk);
    end
    @(negedge clk);
    wdata = wd[3]; rst = 1'b1; #1;
    n_vec++;
    if (wready !== 1'b0 || wlast !== 1'b0 || awready !== 1'b0 || arready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_forced: wready=%b wlast=%b awready=%b arready=%b, required 0000",
               wready, wlast, awready, arready);
    end
    @(negedge clk);
    wvalid = 1'b0; #1;
    n_vec++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== '0 ||
        rid !== 4'd0 || bid !== 4'd0 || wready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: bvalid=%b rvalid=%b rlast=%b rid=%h bid=%h wready=%b, required all 0",
               bvalid, rvalid, rlast, rid, bid, wready);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (bvalid !== 1'b0 || wready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_no_resp: bvalid=%b wready=%b, required 0/0", bvalid, wready);
    end
    axi_read(28'h20, 4'h3, 4'd0, -1, 0, 1'b0, "rst_mid_r0", d);
    axi_read(28'h38, 4'h4, 4'd0, -1, 0, 1'b0, "rst_mid_r3", d);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_arbitration();
    test_write_read();
    test_strobes();
    test_wrap();
    test_stalls();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
